// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and request-controller FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_SLT     = 4'd4;
    localparam logic [3:0] ALU_OP_LAST = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

    // Opcodes above ALU_OP_LAST are undefined and must never reach the ALU.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= ALU_OP_LAST;
    endfunction

endpackage

// File: rtl/alu_req_ctrl.sv
// Request/response wrapper around the combinational ALU: accepts one op,
// holds the ALU inputs for a full cycle, captures the result, returns it tagged.
module alu_req_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned TW = 4,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_op,
    input  logic [W-1:0]  req_a,
    input  logic [W-1:0]  req_b,
    input  logic [TW-1:0] req_tag,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [3:0]    alu_s,
    input  logic [W-1:0]  alu_z,
    input  logic          alu_zf,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_z,
    output logic          rsp_zf,
    output logic          rsp_err,
    output logic [TW-1:0] rsp_tag,
    output logic          busy,
    output logic [CW-1:0] op_count
);

    ctrl_state_t state;

    // Handshake status decoded directly from the state register.
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
    end

    // Control FSM with registered ALU drive, response fields and op counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            rsp_valid <= 1'b0;
            rsp_z     <= '0;
            rsp_zf    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_tag   <= '0;
            op_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_tag <= req_tag;
                        if (is_legal_op(req_op)) begin
                            alu_a <= req_a;
                            alu_b <= req_b;
                            alu_s <= req_op;
                            state <= EXEC;
                        end else begin
                            // Rejected without touching the ALU inputs.
                            rsp_z     <= '0;
                            rsp_zf    <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for this whole cycle.
                    rsp_z     <= alu_z;
                    rsp_zf    <= alu_zf;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                        if (!rsp_err) begin
                            op_count <= op_count + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
